// File: rtl/dmux8_way_pkg.sv
// Shared types for the dmux8_way slice: the 14-bit registered result
// bundle and its cleared value.
package dmux8_way_pkg;

  localparam int Y2_W = 2;
  localparam int Y4_W = 4;
  localparam int Y8_W = 8;

  typedef struct packed {
    logic [Y2_W-1:0] y2;
    logic [Y4_W-1:0] y4;
    logic [Y8_W-1:0] y8;
  } dmux_out_t;

  localparam dmux_out_t OUT_ZERO = '{y2: 2'b00, y4: 4'b0000, y8: 8'h00};

endpackage

// File: rtl/dmux8_way_cell.sv
// Combinational 1:2 demux leaf used to build the dmux8_way select tree.
module dmux_cell (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);

  assign a = in & ~sel;
  assign b = in & sel;

endmodule

// File: rtl/dmux8_way.sv
// Registered 1:2 / 1:4 / 1:8 demux built as a dmux_cell tree
// (sel[2] at the root, then sel[1], then sel[0]), MSB-first output ordering.
module dmux8_way
  import dmux8_way_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in,
  input  logic [2:0] sel,
  output logic [1:0] y2,
  output logic [3:0] y4,
  output logic [7:0] y8
);

  logic [1:0] lvl2_s;
  logic [3:0] lvl4_s;
  logic [7:0] lvl8_s;
  dmux_out_t  next_s;
  dmux_out_t  out_r;

  // Node at bit p of one level feeds bits 2p+1 (sel=0) and 2p (sel=1) of the next.
  dmux_cell u_root (
    .in  (in),
    .sel (sel[2]),
    .a   (lvl2_s[1]),
    .b   (lvl2_s[0])
  );

  for (genvar p = 0; p < 2; p++) begin : g_lvl4
    dmux_cell u_cell (
      .in  (lvl2_s[p]),
      .sel (sel[1]),
      .a   (lvl4_s[2*p+1]),
      .b   (lvl4_s[2*p])
    );
  end

  for (genvar q = 0; q < 4; q++) begin : g_lvl8
    dmux_cell u_cell (
      .in  (lvl4_s[q]),
      .sel (sel[0]),
      .a   (lvl8_s[2*q+1]),
      .b   (lvl8_s[2*q])
    );
  end

  // Bundle the three tree levels so they are captured together.
  always_comb begin
    next_s    = OUT_ZERO;
    next_s.y2 = lvl2_s;
    next_s.y4 = lvl4_s;
    next_s.y8 = lvl8_s;
  end

  // Single output register stage; reset dominates enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= OUT_ZERO;
    end else if (en) begin
      out_r <= next_s;
    end else begin
      out_r <= out_r;
    end
  end

  assign y2 = out_r.y2;
  assign y4 = out_r.y4;
  assign y8 = out_r.y8;

endmodule

// File: tb/tb_dmux8_way.sv
// Self-checking bench for dmux8_way: directed vector table, reset sequences
// and a randomized run against a shift-based reference model.
module tb_dmux8_way;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       in  = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [1:0] y2;
  logic [3:0] y4;
  logic [7:0] y8;

  int compared   = 0;
  int mismatched = 0;

  dmux8_way dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in  (in),
    .sel (sel),
    .y2  (y2),
    .y4  (y4),
    .y8  (y8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       in;
    logic [2:0] sel;
    logic       en;
    logic [1:0] y2;
    logic [3:0] y4;
    logic [7:0] y8;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [13:0] model(input logic i, input logic [2:0] s);
    logic [1:0] e2;
    logic [3:0] e4;
    logic [7:0] e8;
    int k;
    k  = int'(s);
    e8 = i ? (8'h80 >> k) : 8'h00;
    e4 = i ? (4'b1000 >> (k / 2)) : 4'b0000;
    e2 = i ? (2'b10 >> (k / 4)) : 2'b00;
    return {e2, e4, e8};
  endfunction

  task automatic chk(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {y2, y4, y8};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got y2=%b y4=%b y8=%h, expected y2=%b y4=%b y8=%h",
               name, act[13:12], act[11:8], act[7:0], exp[13:12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic onehot_chk(input string name);
    compared++;
    if ($countones(y2) > 1 || $countones(y4) > 1 || $countones(y8) > 1) begin
      mismatched++;
      $display("FAIL %s: got y2=%b y4=%b y8=%h, expected at most one bit set per output",
               name, y2, y4, y8);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] exp_q;
  logic        ri, ren;
  logic [2:0]  rsel;

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 1'b1, 2'b10, 4'b1000, 8'h80};
    vecs[1]  = '{1'b1, 3'd1, 1'b1, 2'b10, 4'b1000, 8'h40};
    vecs[2]  = '{1'b1, 3'd2, 1'b1, 2'b10, 4'b0100, 8'h20};
    vecs[3]  = '{1'b1, 3'd3, 1'b1, 2'b10, 4'b0100, 8'h10};
    vecs[4]  = '{1'b1, 3'd4, 1'b1, 2'b01, 4'b0010, 8'h08};
    vecs[5]  = '{1'b1, 3'd5, 1'b1, 2'b01, 4'b0010, 8'h04};
    vecs[6]  = '{1'b1, 3'd6, 1'b1, 2'b01, 4'b0001, 8'h02};
    vecs[7]  = '{1'b1, 3'd7, 1'b1, 2'b01, 4'b0001, 8'h01};
    vecs[8]  = '{1'b1, 3'd5, 1'b1, 2'b01, 4'b0010, 8'h04};
    vecs[9]  = '{1'b0, 3'd5, 1'b1, 2'b00, 4'b0000, 8'h00};
    vecs[10] = '{1'b1, 3'd2, 1'b1, 2'b10, 4'b0100, 8'h20};
    vecs[11] = '{1'b0, 3'd6, 1'b0, 2'b10, 4'b0100, 8'h20};
    vecs[12] = '{1'b0, 3'd6, 1'b0, 2'b10, 4'b0100, 8'h20};

    // Reset held with active inputs and running clock.
    rst = 1'b1; in = 1'b1; sel = 3'd3; en = 1'b1;
    #1;
    chk("reset_async", 14'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_held", 14'd0);
    end
    rst = 1'b0;

    // Directed table: sel sweep, in=1 then 0, load then hold.
    for (int i = 0; i < 13; i++) begin
      in = vecs[i].in; sel = vecs[i].sel; en = vecs[i].en;
      step();
      chk($sformatf("vec%0d", i), {vecs[i].y2, vecs[i].y4, vecs[i].y8});
    end
    // Third hold cycle with toggling inputs.
    in = 1'b1; sel = 3'd7;
    #2 in = 1'b0; sel = 3'd6;
    step();
    chk("hold3", {2'b10, 4'b0100, 8'h20});

    // Reset between edges clears immediately, then reload.
    in = 1'b1; sel = 3'd7; en = 1'b1;
    step();
    chk("pre_rst_load", {2'b01, 4'b0001, 8'h01});
    #2 rst = 1'b1;
    #1 chk("mid_rst_clear", 14'd0);
    #2 rst = 1'b0;
    in = 1'b1; sel = 3'd0; en = 1'b1;
    step();
    chk("post_rst_load", {2'b10, 4'b1000, 8'h80});

    // Randomized run with between-edge glitches on in/sel.
    exp_q = {2'b10, 4'b1000, 8'h80};
    for (int c = 0; c < 1000; c++) begin
      ri   = 1'($urandom_range(0, 1));
      rsel = 3'($urandom_range(0, 7));
      ren  = ($urandom_range(0, 3) != 0);
      in = ~ri; sel = ~rsel; en = ren;
      #2;
      in = ri; sel = rsel;
      step();
      if (ren) exp_q = model(ri, rsel);
      chk($sformatf("rand%0d", c), exp_q);
      onehot_chk($sformatf("onehot%0d", c));
      in = ~ri; sel = rsel + 3'd3;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
